dti_uart_rx_fifo: RTL and testbench
===================================

// Module: dti_uart_rx_fifo
// PURPOSE
// - Receive-side buffer between the UART receiver and the APB register block.
// - Captures each completed frame from the receiver's held rx_done/rx_data status.
// - Returns a one-cycle acknowledge to the receiver, then stores the frame in a DEPTH-entry FIFO.
// - Presents the FIFO head, fill level, overrun and flow-control status to the register block.
// PARAMETERS
// - DATA_WIDTH  default 8 : frame data width; must be 8 (the 5..8-bit masking below assumes 8).
// - DEPTH       default 16 : FIFO entries; power of 2, >= 4.
// - AF_MARGIN   default 2 : flow_stop asserts when count >= DEPTH-AF_MARGIN; 1 <= AF_MARGIN < DEPTH.
// PORTS
// - clk               in   1               : single clock for all logic
// - reset             in   1               : asynchronous, active-high reset
// - rx_done           in   1               : receiver frame-ready status; held high until acked
// - rx_data           in   DATA_WIDTH      : received frame, valid while rx_done=1
// - cfg_data_bit_num  in   2               : 00=5, 01=6, 10=7, 11=8 data bits
// - rx_ack            out  1               : 1-cycle pulse, frame taken; receiver clears rx_done
// - pop               in   1               : register-block read of the head entry (1-cycle pulse)
// - rd_data           out  DATA_WIDTH      : head entry; 0 when empty
// - empty             out  1               : FIFO empty
// - full              out  1               : FIFO full
// - count             out  $clog2(DEPTH)+1 : number of stored entries
// - overrun           out  1               : sticky, a frame was dropped because the FIFO was full
// - ovr_clr           in   1               : clears overrun (write-1-to-clear strobe)
// - flow_stop         out  1               : registered almost-full, for RTS de-assertion
// BEHAVIOUR
// - Reset (async, active-high):
//   - state=IDLE, pointers=0, count=0, empty=1, full=0.
//   - rx_ack=0, overrun=0, flow_stop=0, rd_data=0.
//   - Memory contents are not reset.
// - Capture FSM:
//   - IDLE: rx_data is sampled and masked on the edge where rx_done=1 is seen.
//     - Goes to ACK next cycle.
//   - ACK: rx_ack=1 for exactly this cycle.
//     - Push occurs this cycle; see the push rules below.
//     - Next state is WAIT.
//   - WAIT: rx_ack=0; stay while rx_done=1.
//     - Return to IDLE on rx_done=0.
//     - Guarantees one push per frame even if rx_done clears late.
//   - Latency: rx_done rise -> rx_ack high 1 clk later.
//     - The entry is visible (count/empty updated) on the clk after ACK.
// - Masking: bits >= the configured data-bit count are zeroed before storage.
//   - Example: 5-bit mode stores rx_data & 8'h1F.
// - Push rules (in ACK):
//   - If full=0, or full=1 with pop=1 in the same cycle: write mem[wr_ptr], wr_ptr++.
//   - Else drop the frame and set overrun.
//   - rx_ack is still pulsed, so the receiver never stalls.
// - Pop rules:
//   - pop with empty=0: rd_ptr++.
//   - pop with empty=1: ignored; no pointer or count change, no error flag.
// - Simultaneous push and pop: count unchanged, both pointers advance.
//   - Valid when full and when count=1.
// - Pointers wrap modulo DEPTH.
// - full  = count==DEPTH.
// - empty = count==0.
// - rd_data = mem[rd_ptr] when !empty, else 0.
//   - Combinational from registered state; no read latency.
// - overrun:
//   - Set on a drop; cleared by ovr_clr.
//   - Drop and ovr_clr in the same cycle: set wins.
// - flow_stop:
//   - Registered: count_next >= DEPTH-AF_MARGIN, evaluated every cycle.
//   - Deasserts once count_next drops below the threshold.
// - cfg_data_bit_num change mid-operation: affects only frames sampled afterwards.
// - Reset mid-frame (any state): returns to IDLE.
//   - A frame still held by the receiver is captured after reset release.
// TESTING
// - Reset, then a single frame (rx_done=1, rx_data=8'hA5, mode 11):
//   - rx_ack pulses exactly 1 clk.
//   - count=1, rd_data=8'hA5.
//   - pop gives count=0, empty=1, rd_data=0.
// - Mode 00, rx_data=8'hFF -> stored 8'h1F.
//   - Mode 10, rx_data=8'hFF -> stored 8'h7F.
// - 16 frames 8'h00..8'h0F, then frame 8'h10:
//   - full=1 after the 16th.
//   - 17th is dropped with overrun=1, rx_ack still pulsed.
//   - 16 pops return 00..0F in order, wrap correct.
// - Full FIFO, 17th frame's ACK cycle coincident with pop:
//   - No overrun, count stays 16.
//   - Last entry popped is 8'h10.
// - With DEPTH=16, AF_MARGIN=2:
//   - flow_stop rises on the clk count reaches 14.
//   - Falls when count returns to 13.
// - rx_done held high 10 clks: exactly one push and one rx_ack.
//   - Async reset asserted in WAIT with count=5: count=0, rx_ack=0.
//   - Held frame is re-captured after release.
//   - ovr_clr coincident with a drop: overrun stays 1.

Source files
------------

// File: rtl/dti_uart_rx_fifo.sv
// Receive-side frame buffer: captures held rx_done/rx_data frames with a one-cycle ack,
// stores them in a DEPTH-entry FIFO and reports head, fill level, overrun and flow control.
module dti_uart_rx_fifo #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 16,
    parameter int AF_MARGIN  = 2
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      rx_done,
    input  logic [DATA_WIDTH-1:0]     rx_data,
    input  logic [1:0]                cfg_data_bit_num,
    output logic                      rx_ack,
    input  logic                      pop,
    output logic [DATA_WIDTH-1:0]     rd_data,
    output logic                      empty,
    output logic                      full,
    output logic [$clog2(DEPTH):0]    count,
    output logic                      overrun,
    input  logic                      ovr_clr,
    output logic                      flow_stop
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
    localparam logic [CW-1:0] AF_LEVEL = CW'(DEPTH - AF_MARGIN);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ACK  = 2'd1,
        S_WAIT = 2'd2
    } state_t;

    state_t                r_state;
    logic                  r_rx_ack;
    logic [DATA_WIDTH-1:0] r_frame;
    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]         r_wr_ptr;
    logic [PW-1:0]         r_rd_ptr;
    logic [CW-1:0]         r_count;
    logic                  r_overrun;
    logic                  r_flow_stop;

    logic [DATA_WIDTH-1:0] w_mask;
    logic                  w_full;
    logic                  w_empty;
    logic                  w_pop;
    logic                  w_push;
    logic                  w_drop;
    logic [CW-1:0]         w_count_next;

    // Mode 11 keeps all 8 bits; each lower mode drops one more MSB.
    assign w_mask  = {DATA_WIDTH{1'b1}} >> (2'd3 - cfg_data_bit_num);

    assign w_full  = (r_count == DEPTH_C);
    assign w_empty = (r_count == '0);
    assign w_pop   = pop && !w_empty;
    // A full FIFO still accepts the frame when a pop frees a slot in the same cycle.
    assign w_push  = (r_state == S_ACK) && (!w_full || w_pop);
    assign w_drop  = (r_state == S_ACK) && !w_push;

    always_comb begin
        w_count_next = r_count;
        case ({w_push, w_pop})
            2'b10:   w_count_next = r_count + CW'(1);
            2'b01:   w_count_next = r_count - CW'(1);
            default: w_count_next = r_count;
        endcase
    end

    // NOTE: all sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= S_IDLE;
            r_rx_ack <= 1'b0;
            r_frame  <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (rx_done) begin
                        r_frame  <= rx_data & w_mask;
                        r_rx_ack <= 1'b1;
                        r_state  <= S_ACK;
                    end
                end
                S_ACK: begin
                    r_rx_ack <= 1'b0;
                    r_state  <= S_WAIT;
                end
                S_WAIT: begin
                    // Hold off until the receiver drops rx_done so a frame is pushed only once.
                    if (!rx_done) r_state <= S_IDLE;
                end
                default: begin
                    r_rx_ack <= 1'b0;
                    r_state  <= S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_overrun   <= 1'b0;
            r_flow_stop <= 1'b0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
            r_count     <= w_count_next;
            r_flow_stop <= (w_count_next >= AF_LEVEL);
            // A drop in the same cycle as a clear must leave the flag set.
            if (w_drop)       r_overrun <= 1'b1;
            else if (ovr_clr) r_overrun <= 1'b0;
        end
    end

    // NOTE: storage has no reset; empty/count gate every read, so stale contents are never visible.
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= r_frame;
    end

    assign rd_data   = w_empty ? '0 : r_mem[r_rd_ptr];
    assign rx_ack    = r_rx_ack;
    assign empty     = w_empty;
    assign full      = w_full;
    assign count     = r_count;
    assign overrun   = r_overrun;
    assign flow_stop = r_flow_stop;

endmodule

// File: tb/tb_dti_uart_rx_fifo.sv
// Directed bench for dti_uart_rx_fifo: frames are driven through the receiver handshake,
// expected entries are queued in a scoreboard and compared when the FIFO head is popped.
module tb_dti_uart_rx_fifo;

    localparam int DW        = 8;
    localparam int DEPTH     = 16;
    localparam int AF_MARGIN = 2;

    logic          clk;
    logic          reset;
    logic          rx_done;
    logic [DW-1:0] rx_data;
    logic [1:0]    cfg_data_bit_num;
    logic          rx_ack;
    logic          pop;
    logic [DW-1:0] rd_data;
    logic          empty;
    logic          full;
    logic [4:0]    count;
    logic          overrun;
    logic          ovr_clr;
    logic          flow_stop;

    int            n_checks = 0;
    int            n_pass   = 0;
    int            n_fail   = 0;
    int            ack_cnt  = 0;
    logic [7:0]    sb[$];
    logic          exp_ovr  = 1'b0;

    dti_uart_rx_fifo #(
        .DATA_WIDTH(DW),
        .DEPTH     (DEPTH),
        .AF_MARGIN (AF_MARGIN)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .rx_done         (rx_done),
        .rx_data         (rx_data),
        .cfg_data_bit_num(cfg_data_bit_num),
        .rx_ack          (rx_ack),
        .pop             (pop),
        .rd_data         (rd_data),
        .empty           (empty),
        .full            (full),
        .count           (count),
        .overrun         (overrun),
        .ovr_clr         (ovr_clr),
        .flow_stop       (flow_stop)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) if (rx_ack === 1'b1) ack_cnt++;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] mask(input logic [7:0] d, input logic [1:0] m);
        case (m)
            2'b00:   return d & 8'h1F;
            2'b01:   return d & 8'h3F;
            2'b10:   return d & 8'h7F;
            default: return d;
        endcase
    endfunction

    // Called at a negedge; returns at a negedge with the capture FSM back in IDLE.
    task automatic send_frame(input logic [7:0] d, input logic [1:0] mode, input int hold,
                              input bit pop_at_ack, input bit clr_at_ack);
        bit         seen;
        bit         was_full;
        bit         dropped;
        int         acks0;
        logic [7:0] head;
        acks0 = ack_cnt;
        @(negedge clk);
        cfg_data_bit_num = mode;
        rx_data          = d;
        rx_done          = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 4 && !seen; i++) begin
            @(negedge clk);
            if (rx_ack === 1'b1) seen = 1'b1;
        end
        check("ack_seen", 32'(seen), 32'd1);
        was_full = (sb.size() == DEPTH);
        if (pop_at_ack && sb.size() > 0) begin
            head = sb.pop_front();
            check("head_at_ack", 32'(rd_data), 32'(head));
            pop = 1'b1;
        end
        ovr_clr = clr_at_ack;
        dropped = was_full && !pop_at_ack;
        if (dropped) exp_ovr = 1'b1;
        else begin
            sb.push_back(mask(d, mode));
            if (clr_at_ack) exp_ovr = 1'b0;
        end
        @(negedge clk);
        pop     = 1'b0;
        ovr_clr = 1'b0;
        check("ack_one_cycle", 32'(rx_ack), 32'd0);
        check("count_after_ack", 32'(count), 32'(sb.size()));
        check("flow_stop_push", 32'(flow_stop), 32'(sb.size() >= DEPTH - AF_MARGIN));
        check("overrun", 32'(overrun), 32'(exp_ovr));
        check("full", 32'(full), 32'(sb.size() == DEPTH));
        repeat (hold) @(negedge clk);
        rx_done = 1'b0;
        repeat (2) @(negedge clk);
        check("ack_pulses", 32'(ack_cnt - acks0), 32'd1);
        check("count_settled", 32'(count), 32'(sb.size()));
    endtask

    // Called at a negedge; compares the head with the scoreboard, pops it.
    task automatic pop_one(input string tag);
        logic [7:0] head;
        head = sb.pop_front();
        check(tag, 32'(rd_data), 32'(head));
        pop = 1'b1;
        @(negedge clk);
        pop = 1'b0;
        check("count_after_pop", 32'(count), 32'(sb.size()));
        check("empty_after_pop", 32'(empty), 32'(sb.size() == 0));
        check("flow_stop_pop", 32'(flow_stop), 32'(sb.size() >= DEPTH - AF_MARGIN));
    endtask

    initial begin
        bit         seen;
        logic [7:0] last;
        reset            = 1'b1;
        rx_done          = 1'b0;
        rx_data          = '0;
        cfg_data_bit_num = 2'b11;
        pop              = 1'b0;
        ovr_clr          = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_count", 32'(count), 32'd0);
        check("rst_empty", 32'(empty), 32'd1);
        check("rst_full", 32'(full), 32'd0);
        check("rst_ack", 32'(rx_ack), 32'd0);
        check("rst_overrun", 32'(overrun), 32'd0);
        check("rst_flow_stop", 32'(flow_stop), 32'd0);
        check("rst_rd_data", 32'(rd_data), 32'd0);
        reset = 1'b0;
        @(negedge clk);

        // Single 8-bit frame
        send_frame(8'hA5, 2'b11, 0, 1'b0, 1'b0);
        check("single_rd_data", 32'(rd_data), 32'hA5);
        pop_one("single_pop");
        check("empty_rd_data", 32'(rd_data), 32'd0);

        // Width masking
        send_frame(8'hFF, 2'b00, 0, 1'b0, 1'b0);
        send_frame(8'hFF, 2'b10, 0, 1'b0, 1'b0);
        check("mask5_head", 32'(rd_data), 32'h1F);
        pop_one("mask5_pop");
        pop_one("mask7_pop");

        // Pop on empty is ignored
        pop = 1'b1;
        @(negedge clk);
        pop = 1'b0;
        check("pop_empty_count", 32'(count), 32'd0);
        check("pop_empty_ovr", 32'(overrun), 32'd0);

        // Fill to full, then drop with a coincident clear (set wins)
        for (int i = 0; i < DEPTH; i++) send_frame(8'(i), 2'b11, 0, 1'b0, 1'b0);
        check("full_after_16", 32'(full), 32'd1);
        send_frame(8'h10, 2'b11, 0, 1'b0, 1'b1);
        check("drop_overrun", 32'(overrun), 32'd1);
        check("drop_count", 32'(count), 32'd16);
        ovr_clr = 1'b1;
        @(negedge clk);
        ovr_clr = 1'b0;
        exp_ovr = 1'b0;
        check("ovr_clr", 32'(overrun), 32'd0);
        for (int i = 0; i < DEPTH; i++) pop_one("drain_order");

        // Full FIFO with pop during the ACK cycle
        for (int i = 0; i < DEPTH; i++) send_frame(8'(i), 2'b11, 0, 1'b0, 1'b0);
        send_frame(8'h10, 2'b11, 0, 1'b1, 1'b0);
        check("pushpop_full_ovr", 32'(overrun), 32'd0);
        check("pushpop_full_count", 32'(count), 32'd16);
        last = 8'h00;
        while (sb.size() > 0) begin
            last = sb[sb.size()-1];
            pop_one("pushpop_drain");
        end
        check("pushpop_last", 32'(last), 32'h10);

        // Push and pop together at count=1
        send_frame(8'h21, 2'b11, 0, 1'b0, 1'b0);
        send_frame(8'h22, 2'b11, 0, 1'b1, 1'b0);
        check("pushpop_one_head", 32'(rd_data), 32'h22);
        pop_one("pushpop_one_pop");

        // rx_done held long: one push, one ack
        send_frame(8'h5A, 2'b11, 9, 1'b0, 1'b0);
        check("hold_count", 32'(count), 32'd1);

        // Reset while in WAIT with count=5, held frame re-captured afterwards
        for (int i = 0; i < 3; i++) send_frame(8'h60 + 8'(i), 2'b11, 0, 1'b0, 1'b0);
        @(negedge clk);
        rx_data          = 8'h3C;
        cfg_data_bit_num = 2'b11;
        rx_done          = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 4 && !seen; i++) begin
            @(negedge clk);
            if (rx_ack === 1'b1) seen = 1'b1;
        end
        check("rst_wait_ack_seen", 32'(seen), 32'd1);
        @(negedge clk);
        check("rst_wait_count5", 32'(count), 32'd5);
        reset = 1'b1;
        #1;
        check("rst_mid_count", 32'(count), 32'd0);
        check("rst_mid_ack", 32'(rx_ack), 32'd0);
        check("rst_mid_empty", 32'(empty), 32'd1);
        check("rst_mid_flow", 32'(flow_stop), 32'd0);
        sb.delete();
        exp_ovr = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 4 && !seen; i++) begin
            @(negedge clk);
            if (rx_ack === 1'b1) seen = 1'b1;
        end
        check("recapture_ack", 32'(seen), 32'd1);
        sb.push_back(8'h3C);
        @(negedge clk);
        check("recapture_count", 32'(count), 32'd1);
        rx_done = 1'b0;
        repeat (2) @(negedge clk);
        pop_one("recapture_data");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
